// File: rtl/control_sequencer.sv
// NSC-8 microstep sequencer: T0..T4 step counter, opcode decode and HALT latch.
// Drives every datapath load/enable strobe combinationally from (step, opcode, flags).
module control_sequencer #(
  parameter int X = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic [X-1:0] instr,
  input  logic         carry_flag,
  input  logic         zero_flag,
  output logic         pc_out,
  output logic         pc_inc,
  output logic         pc_load,
  output logic         mar_load,
  output logic         ram_out,
  output logic         ram_write,
  output logic         ir_load,
  output logic         ir_out,
  output logic         load_a,
  output logic         load_immediate_a,
  output logic         a_out,
  output logic         load_b,
  output logic         alu_out,
  output logic         alu_sub,
  output logic         flags_load,
  output logic         out_load,
  output logic         halted
);

  localparam int OW = X / 2;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  localparam logic [OW-1:0] OP_LDA = OW'(1);
  localparam logic [OW-1:0] OP_ADD = OW'(2);
  localparam logic [OW-1:0] OP_SUB = OW'(3);
  localparam logic [OW-1:0] OP_STA = OW'(4);
  localparam logic [OW-1:0] OP_LDI = OW'(5);
  localparam logic [OW-1:0] OP_JMP = OW'(6);
  localparam logic [OW-1:0] OP_JC  = OW'(7);
  localparam logic [OW-1:0] OP_JZ  = OW'(8);
  localparam logic [OW-1:0] OP_OUT = OW'(14);
  localparam logic [OW-1:0] OP_HLT = OW'(15);

  logic [2:0]    step_q, step_d;
  logic          halted_q, halted_d;
  logic [OW-1:0] opcode;
  logic [2:0]    last_step;
  logic          active;
  logic          unused_operand;

  assign opcode         = instr[X-1:OW];
  assign unused_operand = ^instr[OW-1:0];
  assign halted         = halted_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    last_step = T1;
    case (opcode)
      OP_LDA, OP_STA:                                 last_step = T3;
      OP_ADD, OP_SUB:                                 last_step = T4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:   last_step = T2;
      default:                                        last_step = T1;
    endcase
  end

  // >= rather than == so an IR change mid-instruction still lands back on T0.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q && run) begin
      if (step_q == T2 && opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else if (step_q >= last_step) begin
        step_d = T0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  assign active = !reset && run && !halted_q;

  always_comb begin
    pc_out           = 1'b0;
    pc_inc           = 1'b0;
    pc_load          = 1'b0;
    mar_load         = 1'b0;
    ram_out          = 1'b0;
    ram_write        = 1'b0;
    ir_load          = 1'b0;
    ir_out           = 1'b0;
    load_a           = 1'b0;
    load_immediate_a = 1'b0;
    a_out            = 1'b0;
    load_b           = 1'b0;
    alu_out          = 1'b0;
    alu_sub          = 1'b0;
    flags_load       = 1'b0;
    out_load         = 1'b0;
    if (active) begin
      case (step_q)
        T0: begin
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        T1: begin
          ram_out = 1'b1;
          ir_load = 1'b1;
          pc_inc  = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_out   = 1'b1;
              mar_load = 1'b1;
            end
            OP_LDI: begin
              ir_out           = 1'b1;
              load_immediate_a = 1'b1;
            end
            OP_JMP: begin
              ir_out  = 1'b1;
              pc_load = 1'b1;
            end
            OP_JC: begin
              ir_out  = carry_flag;
              pc_load = carry_flag;
            end
            OP_JZ: begin
              ir_out  = zero_flag;
              pc_load = zero_flag;
            end
            OP_OUT: begin
              a_out    = 1'b1;
              out_load = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              ram_out = 1'b1;
              load_a  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_out = 1'b1;
              load_b  = 1'b1;
            end
            OP_STA: begin
              a_out     = 1'b1;
              ram_write = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_out    = 1'b1;
            load_a     = 1'b1;
            flags_load = 1'b1;
            alu_sub    = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each opcode step by step against
// hand-written strobe patterns and checks the single-bus-driver rule every cycle.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] instr;
  logic       carry_flag;
  logic       zero_flag;
  logic pc_out, pc_inc, pc_load, mar_load, ram_out, ram_write, ir_load, ir_out;
  logic load_a, load_immediate_a, a_out, load_b, alu_out, alu_sub, flags_load, out_load;
  logic halted;

  int tests = 0;
  int fails = 0;

  // Strobe vector bit positions, MSB first in port order.
  localparam logic [15:0] PC_OUT = 16'h8000;
  localparam logic [15:0] PC_INC = 16'h4000;
  localparam logic [15:0] PC_LD  = 16'h2000;
  localparam logic [15:0] MAR_LD = 16'h1000;
  localparam logic [15:0] RAM_O  = 16'h0800;
  localparam logic [15:0] RAM_W  = 16'h0400;
  localparam logic [15:0] IR_LD  = 16'h0200;
  localparam logic [15:0] IR_O   = 16'h0100;
  localparam logic [15:0] A_LD   = 16'h0080;
  localparam logic [15:0] A_IMM  = 16'h0040;
  localparam logic [15:0] A_O    = 16'h0020;
  localparam logic [15:0] B_LD   = 16'h0010;
  localparam logic [15:0] ALU_O  = 16'h0008;
  localparam logic [15:0] ALU_S  = 16'h0004;
  localparam logic [15:0] FL_LD  = 16'h0002;
  localparam logic [15:0] OUT_LD = 16'h0001;
  localparam logic [15:0] NONE   = 16'h0000;
  localparam logic [15:0] S_T0   = PC_OUT | MAR_LD;
  localparam logic [15:0] S_T1   = RAM_O | IR_LD | PC_INC;

  logic [15:0] strobes;
  logic [4:0]  bus;
  assign strobes = {pc_out, pc_inc, pc_load, mar_load, ram_out, ram_write, ir_load, ir_out,
                    load_a, load_immediate_a, a_out, load_b, alu_out, alu_sub, flags_load, out_load};
  assign bus = {pc_out, ram_out, ir_out, a_out, alu_out};

  control_sequencer #(.X(8)) dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .ram_out(ram_out), .ram_write(ram_write), .ir_load(ir_load), .ir_out(ir_out),
    .load_a(load_a), .load_immediate_a(load_immediate_a), .a_out(a_out),
    .load_b(load_b), .alu_out(alu_out), .alu_sub(alu_sub), .flags_load(flags_load),
    .out_load(out_load), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    #2;
    tests++;
    assert ($onehot0(bus) === 1'b1) else begin
      fails++;
      $error("FAIL bus_driver: got drivers %b required at most one high", bus);
    end
  end

  task automatic check(input string tag, input logic [15:0] exp_s, input logic exp_h);
    #1;
    tests++;
    assert (strobes === exp_s) else begin
      fails++;
      $error("FAIL %s strobes: got %h required %h", tag, strobes, exp_s);
    end
    tests++;
    assert (halted === exp_h) else begin
      fails++;
      $error("FAIL %s halted: got %b required %b", tag, halted, exp_h);
    end
    $display("[TB] %s strobes=%h halted=%b", tag, strobes, halted);
  endtask

  // Check the current cycle, then move to the next negedge.
  task automatic cyc(input string tag, input logic [15:0] exp_s);
    check(tag, exp_s, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; instr = 8'h5A; carry_flag = 1'b0; zero_flag = 1'b0;
    @(negedge clk);
    check("reset_state", NONE, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // LDI
    cyc("ldi_t0", S_T0);
    cyc("ldi_t1", S_T1);
    cyc("ldi_t2", IR_O | A_IMM);
    // ADD then SUB
    instr = 8'h23;
    cyc("add_t0", S_T0);
    cyc("add_t1", S_T1);
    cyc("add_t2", IR_O | MAR_LD);
    cyc("add_t3", RAM_O | B_LD);
    cyc("add_t4", ALU_O | A_LD | FL_LD);
    instr = 8'h33;
    cyc("sub_t0", S_T0);
    cyc("sub_t1", S_T1);
    cyc("sub_t2", IR_O | MAR_LD);
    cyc("sub_t3", RAM_O | B_LD);
    cyc("sub_t4", ALU_O | A_LD | FL_LD | ALU_S);
    // JC untaken / taken
    instr = 8'h74; carry_flag = 1'b0;
    cyc("jc0_t0", S_T0);
    cyc("jc0_t1", S_T1);
    cyc("jc0_t2", NONE);
    carry_flag = 1'b1;
    cyc("jc1_t0", S_T0);
    cyc("jc1_t1", S_T1);
    cyc("jc1_t2", IR_O | PC_LD);
    // JZ untaken / taken (carry must not matter)
    instr = 8'h84; zero_flag = 1'b0;
    cyc("jz0_t0", S_T0);
    cyc("jz0_t1", S_T1);
    cyc("jz0_t2", NONE);
    zero_flag = 1'b1; carry_flag = 1'b0;
    cyc("jz1_t0", S_T0);
    cyc("jz1_t1", S_T1);
    cyc("jz1_t2", IR_O | PC_LD);
    // NOP and undefined end after T1
    instr = 8'h00;
    cyc("nop_t0", S_T0);
    cyc("nop_t1", S_T1);
    instr = 8'hB7;
    cyc("undef_t0", S_T0);
    cyc("undef_t1", S_T1);
    // STA, JMP, OUT
    instr = 8'h4C;
    cyc("sta_t0", S_T0);
    cyc("sta_t1", S_T1);
    cyc("sta_t2", IR_O | MAR_LD);
    cyc("sta_t3", A_O | RAM_W);
    instr = 8'h69;
    cyc("jmp_t0", S_T0);
    cyc("jmp_t1", S_T1);
    cyc("jmp_t2", IR_O | PC_LD);
    instr = 8'hE0;
    cyc("out_t0", S_T0);
    cyc("out_t1", S_T1);
    cyc("out_t2", A_O | OUT_LD);
    // LDA with pause in T3
    instr = 8'h1F;
    cyc("lda_t0", S_T0);
    cyc("lda_t1", S_T1);
    cyc("lda_t2", IR_O | MAR_LD);
    run = 1'b0;
    for (int i = 0; i < 5; i++) cyc($sformatf("lda_pause%0d", i), NONE);
    run = 1'b1;
    cyc("lda_t3_resume", RAM_O | A_LD);
    // HLT
    instr = 8'hF0;
    cyc("hlt_t0", S_T0);
    cyc("hlt_t1", S_T1);
    cyc("hlt_t2", NONE);
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      check($sformatf("halted%0d", i), NONE, 1'b1);
      @(negedge clk);
    end
    run = 1'b1; instr = 8'h23;
    reset = 1'b1;
    check("hlt_reset", NONE, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cyc("post_hlt_t0", S_T0);
    cyc("post_hlt_t1", S_T1);
    cyc("rst_add_t2", IR_O | MAR_LD);
    cyc("rst_add_t3", RAM_O | B_LD);
    // Asynchronous reset in the middle of T4
    check("rst_add_t4", ALU_O | A_LD | FL_LD, 1'b0);
    #1 reset = 1'b1;
    check("async_reset_drop", NONE, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cyc("after_rst_t0", S_T0);
    cyc("after_rst_t1", S_T1);
    cyc("after_rst_t2", IR_O | MAR_LD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
